// File: rtl/pc_fetch_ctrl.sv
// Multicycle fetch sequencer for the 16-bit core: owns the PC, runs the
// instruction-memory handshake and holds each instruction until commit.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXC_VEC  = 16'h0002,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_inc,
  input  logic        commit,
  input  logic [15:0] next_pc,
  input  logic        exc,
  input  logic        halt,
  output logic [15:0] epc,
  output logic        halted,
  output logic        err
);

  // state    | meaning
  // ST_RST   | first cycle after reset, no action
  // ST_FETCH | request outstanding at pc, waiting for imem_ack
  // ST_ISSUE | instruction held for decode, waiting for commit
  // ST_STOP  | halted or fetch timeout, terminal until reset
  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] NOP = 16'h0800;

  logic [1:0] state;
  logic [7:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RST;
      pc     <= RESET_PC;
      pc_inc <= RESET_PC + 16'd2;
      instr  <= NOP;
      epc    <= 16'h0000;
      halted <= 1'b0;
      err    <= 1'b0;
      to_cnt <= 8'd0;
    end else begin
      case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          // An ack always wins over a timeout landing in the same cycle.
          if (imem_ack) begin
            instr  <= imem_rdata;
            to_cnt <= 8'd0;
            state  <= ST_ISSUE;
          end else if (to_cnt == TIMEOUT - 8'd1) begin
            to_cnt <= TIMEOUT;
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= ST_STOP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_ISSUE: begin
          if (commit) begin
            if (exc) begin
              epc    <= pc_inc;
              pc     <= EXC_VEC;
              pc_inc <= EXC_VEC + 16'd2;
              state  <= ST_FETCH;
            end else if (halt) begin
              pc     <= pc_inc;
              pc_inc <= pc_inc + 16'd2;
              halted <= 1'b1;
              state  <= ST_STOP;
            end else begin
              pc     <= next_pc;
              pc_inc <= next_pc + 16'd2;
              state  <= ST_FETCH;
            end
          end
        end
        default: state <= ST_STOP;
      endcase
    end
  end

  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_ISSUE);
  assign imem_addr   = pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a memory model pushes expected
// instruction/PC tuples into a scoreboard that is checked when issue begins.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_inc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        commit;
  logic [15:0] next_pc;
  logic        exc;
  logic        halt;
  logic [15:0] epc;
  logic        halted;
  logic        err;

  logic        t_rst_n;
  logic        t_req;
  logic [15:0] t_addr;
  logic        t_ack;
  logic [15:0] t_rdata;
  logic [15:0] t_instr;
  logic        t_valid;
  logic [15:0] t_pc;
  logic [15:0] t_pc_inc;
  logic [15:0] t_epc;
  logic        t_halted;
  logic        t_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_inc(pc_inc), .commit(commit),
    .next_pc(next_pc), .exc(exc), .halt(halt), .epc(epc), .halted(halted),
    .err(err)
  );

  pc_fetch_ctrl #(.TIMEOUT(8'd4)) dut_to (
    .clk(clk), .rst_n(t_rst_n), .imem_req(t_req), .imem_addr(t_addr),
    .imem_ack(t_ack), .imem_rdata(t_rdata), .instr(t_instr),
    .instr_valid(t_valid), .pc(t_pc), .pc_inc(t_pc_inc), .commit(1'b0),
    .next_pc(16'h0000), .exc(1'b0), .halt(1'b0), .epc(t_epc),
    .halted(t_halted), .err(t_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory model: keeps ack low for 'waits' request cycles, then acks with
  // data and records what decode should see once the instruction issues.
  task automatic mem_serve(input int waits, input logic [15:0] data,
                           input logic [15:0] addr);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_req cyc%0d: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 i, imem_req, imem_addr, instr_valid, addr);
      end
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
        e.instr  = data;
        e.pc     = addr;
        e.pc_inc = addr + 16'd2;
        exp_q.push_back(e);
      end
      cyc();
      imem_ack   = 1'b0;
      imem_rdata = 16'(($urandom));
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty at issue");
    end else begin
      e = exp_q.pop_front();
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc || pc_inc !== e.pc_inc
          || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL issue: valid=%b instr=%h pc=%h pc_inc=%h req=%b, required 1 %h %h %h 0",
                 instr_valid, instr, pc, pc_inc, imem_req, e.instr, e.pc, e.pc_inc);
      end
    end
  endtask

  task automatic do_commit(input logic c_exc, input logic c_halt, input logic [15:0] npc);
    commit  = 1'b1;
    exc     = c_exc;
    halt    = c_halt;
    next_pc = npc;
    cyc();
    commit  = 1'b0;
    exc     = 1'b0;
    halt    = 1'b0;
    next_pc = 16'(($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    commit = 1'b0; exc = 1'b0; halt = 1'b0; next_pc = 16'h0000;
    repeat (3) cyc();
    checks++;
    if (pc !== 16'h0000 || pc_inc !== 16'h0002 || imem_req !== 1'b0 || instr !== 16'h0800
        || instr_valid !== 1'b0 || epc !== 16'h0000 || halted !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: pc=%h pc_inc=%h req=%b instr=%h valid=%b epc=%h halted=%b err=%b",
               pc, pc_inc, imem_req, instr, instr_valid, epc, halted, err);
    end
    rst_n = 1'b1;
    // ack stays high through the RST cycle and must be ignored
    cyc();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr !== 16'h0800) begin
      errors++;
      $display("FAIL boot_fetch: req=%b addr=%h instr=%h, required 1 0000 0800",
               imem_req, imem_addr, instr);
    end
    mem_serve(1, 16'h4123, 16'h0000);
  endtask

  task automatic test_normal();
    exc = 1'b1; halt = 1'b1;
    repeat (2) cyc();
    exc = 1'b0; halt = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== 16'h0000 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_commit: valid=%b pc=%h req=%b, required 1 0000 0", instr_valid, pc, imem_req);
    end
    do_commit(1'b0, 1'b0, 16'h0040);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || pc_inc !== 16'h0042 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_commit: req=%b addr=%h pc_inc=%h valid=%b, required 1 0040 0042 0",
               imem_req, imem_addr, pc_inc, instr_valid);
    end
    mem_serve(3, 16'h1A2B, 16'h0040);
    do_commit(1'b0, 1'b0, 16'h0010);
    mem_serve(0, 16'h3C3C, 16'h0010);
  endtask

  task automatic test_exception();
    do_commit(1'b1, 1'b1, 16'h0100);
    checks++;
    if (epc !== 16'h0012 || pc !== 16'h0002 || pc_inc !== 16'h0004 || halted !== 1'b0
        || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL exception: epc=%h pc=%h pc_inc=%h halted=%b req=%b addr=%h, required 0012 0002 0004 0 1 0002",
               epc, pc, pc_inc, halted, imem_req, imem_addr);
    end
    mem_serve(2, 16'h7777, 16'h0002);
    do_commit(1'b0, 1'b0, 16'hFFFE);
    checks++;
    if (epc !== 16'h0012) begin
      errors++;
      $display("FAIL epc_hold: epc=%h, required 0012", epc);
    end
  endtask

  task automatic test_wrap_halt();
    mem_serve(0, 16'h9ABC, 16'hFFFE);
    do_commit(1'b0, 1'b1, 16'h1234);
    checks++;
    if (pc !== 16'h0000 || pc_inc !== 16'h0002 || halted !== 1'b1 || err !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_wrap: pc=%h pc_inc=%h halted=%b err=%b req=%b, required 0000 0002 1 0 0",
               pc, pc_inc, halted, err, imem_req);
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      commit   = 1'($urandom_range(0, 1));
      exc      = 1'($urandom_range(0, 1));
      next_pc  = 16'h0400;
      cyc();
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000 || halted !== 1'b1
          || instr !== 16'h9ABC || epc !== 16'h0012) begin
        errors++;
        $display("FAIL stop_hold cyc%0d: req=%b valid=%b pc=%h halted=%b instr=%h epc=%h",
                 i, imem_req, instr_valid, pc, halted, instr, epc);
      end
    end
    imem_ack = 1'b0; commit = 1'b0; exc = 1'b0;
  endtask

  task automatic test_timeout();
    t_rst_n = 1'b0; t_ack = 1'b0; t_rdata = 16'h0000;
    cyc();
    t_rst_n = 1'b1;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (t_req !== 1'b1 || t_err !== 1'b0 || t_halted !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cyc%0d: req=%b err=%b halted=%b, required 1 0 0", i, t_req, t_err, t_halted);
      end
      cyc();
    end
    checks++;
    if (t_err !== 1'b1 || t_halted !== 1'b1 || t_req !== 1'b0 || t_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: err=%b halted=%b req=%b valid=%b, required 1 1 0 0", t_err, t_halted, t_req, t_valid);
    end
    t_ack = 1'b1;
    repeat (3) cyc();
    t_ack = 1'b0;
    checks++;
    if (t_err !== 1'b1 || t_req !== 1'b0 || t_instr !== 16'h0800) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b req=%b instr=%h, required 1 0 0800", t_err, t_req, t_instr);
    end
    t_rst_n = 1'b0;
    cyc();
    t_rst_n = 1'b1;
    cyc();
    repeat (3) cyc();
    t_ack = 1'b1; t_rdata = 16'h1234;
    cyc();
    t_ack = 1'b0;
    checks++;
    if (t_err !== 1'b0 || t_halted !== 1'b0 || t_valid !== 1'b1 || t_instr !== 16'h1234) begin
      errors++;
      $display("FAIL ack_last_cycle: err=%b halted=%b valid=%b instr=%h, required 0 0 1 1234",
               t_err, t_halted, t_valid, t_instr);
    end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: req=%b, required 0", imem_req);
    end
    rst_n = 1'b1;
    cyc();
    mem_serve(0, 16'h5555, 16'h0000);
    do_commit(1'b1, 1'b0, 16'h0000);
    checks++;
    if (epc !== 16'h0002) begin
      errors++;
      $display("FAIL epc_set: epc=%h, required 0002", epc);
    end
    mem_serve(1, 16'h6666, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 16'h0000 || pc_inc !== 16'h0002 || epc !== 16'h0000
        || imem_req !== 1'b0 || instr !== 16'h0800) begin
      errors++;
      $display("FAIL reset_mid_issue: valid=%b pc=%h pc_inc=%h epc=%h req=%b instr=%h",
               instr_valid, pc, pc_inc, epc, imem_req, instr);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    t_rst_n = 1'b0; t_ack = 1'b0; t_rdata = 16'h0000;
    test_reset();
    test_normal();
    test_exception();
    test_wrap_halt();
    test_timeout();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
